mult_div_unit: RTL and testbench
================================

# mult_div_unit

Iterative 32-bit multiply/divide unit for the multi-cycle CPU, sitting in the EXE stage beside the ALU. It executes MIPS `mult`/`multu`/`div`/`divu` over multiple cycles and holds the 64-bit result in HI/LO. The `result` output is a registered HI or LO selection. It feeds the ALU-output data register in parallel with the ALU through the EXE result mux, serving `mfhi`/`mflo`. The control FSM stalls on `busy` and advances on `done`.

## Interface
- No parameters; datapath width fixed at 32.
- CLK  input  1  rising-edge clock
- Reset  input  1  asynchronous, active-high reset
- start  input  1  operation request; sampled only when busy=0
- op  input  2  00 multu, 01 mult, 10 divu, 11 div
- A  input  32  multiplicand / dividend
- B  input  32  multiplier / divisor
- sel_hi  input  1  result source: 1 = HI, 0 = LO
- busy  output  1  operation in progress
- done  output  1  one-cycle pulse when HI/LO have just been updated
- div_by_zero  output  1  sticky flag; set by a divide with B=0, cleared by the next accepted start
- HI  output  32  upper product / remainder
- LO  output  32  lower product / quotient
- result  output  32  registered mux of HI/LO per sel_hi, updated every edge

## Operation
- States: IDLE, RUN, FIX. Reset forces IDLE and sets HI = LO = result = 0, busy = done = div_by_zero = 0. The reset is asynchronous, takes effect immediately, and aborts any operation in flight.
- **IDLE:**
  - start=1 with B≠0 or a multiply: latch op and operands (magnitudes for signed ops), clear the counter, set busy, go to RUN.
  - start=1 with a divide and B=0: go to FIX directly, with div_by_zero set.
- **RUN, multiply:** shift-add over 32 iterations, one bit of B per cycle, into a 64-bit accumulator.
- **RUN, divide:** restoring division over 32 iterations, one quotient bit per cycle.
- **RUN exit:** counter increments each cycle; at count 31, go to FIX.
- **FIX:**
  - Apply sign correction, then write HI/LO.
  - Assert done for the following cycle, clear busy, and return to IDLE.
- **Signed rules:**
  - Product is the two's-complement 64-bit result.
  - Quotient truncates toward zero; remainder takes the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives LO = 0x80000000, HI = 0.
- **Divide by zero:** HI = A, LO = 0xFFFFFFFF, div_by_zero = 1.
- **Start handling:** start while busy=1 is ignored; no queuing. start in the same cycle done=1 is accepted (busy=0 in that cycle).
- **HI/LO stability:** HI/LO hold their previous values throughout RUN. They change only at the FIX edge.

## Timing
- Start accepted at edge E0; busy=1 from after E0.
- Normal op: RUN covers edges E1–E32, FIX at E33.
  - HI/LO valid and done=1, busy=0 after E33: 33-cycle latency.
  - result reflects the new value after E34.
- Divide by zero: FIX at E1, done after E1, result after E2.
- done is high for exactly one cycle per accepted operation.

## Configuration
- MDU_SIGNED_EN defined: op 01/11 perform signed mult/div per the rules above.
- MDU_SIGNED_EN undefined: op[0] is ignored; all operations are unsigned and no sign-correction logic is built. FIX still takes one cycle, so latency is unchanged.

## Test plan
- multu A=0xFFFFFFFF, B=0xFFFFFFFF -> after 33 cycles HI=0xFFFFFFFE, LO=0x00000001, done pulse 1 cycle.
- mult A=0xFFFFFFFD (-3), B=5 -> HI=0xFFFFFFFF, LO=0xFFFFFFF1. With MDU_SIGNED_EN undefined -> HI=0x00000004, LO=0xFFFFFFF1.
- div A=0xFFFFFFF9 (-7), B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. Separately, div 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
- divu A=100, B=0 -> done after 1 cycle, HI=0x64, LO=0xFFFFFFFF, div_by_zero=1. The next accepted start clears the flag.
- Pulse start with new operands at cycle 10 of a running multu -> ignored, original result delivered, single done pulse.
- Assert Reset mid-RUN (cycle 15) -> busy, done and all registers are 0 immediately. A start after Reset is released completes normally.

Source files
------------

// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative 32-bit multiply/divide unit for the EXE stage.
// Executes multu/mult/divu/div over 32 RUN cycles plus one FIX cycle and
// holds the 64-bit result in HI/LO. Optional macro MDU_SIGNED_EN enables
// signed mult/div (op[0]); without it every operation is unsigned.
module mult_div_unit (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        sel_hi,
  output logic        busy,
  output logic        done,
  output logic        div_by_zero,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] result
);

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t              state, state_nxt;
  logic                accept, dbz_req;
  logic [4:0]          cnt;
  logic                is_div;
  logic [DATA_W-1:0]   acc_hi, acc_lo, opnd;
  logic [DATA_W-1:0]   a_mag, b_mag;
  logic [DATA_W-1:0]   iter_hi, iter_lo;
  logic [DATA_W-1:0]   fix_hi, fix_lo;

  // Per-iteration datapath: shift-add multiply or restoring divide step
  logic [DATA_W:0]     add_sum, shl;
  logic                ge;
  logic [DATA_W-1:0]   diff;

  assign add_sum = {1'b0, acc_hi} + {1'b0, (acc_lo[0] ? opnd : {DATA_W{1'b0}})};
  assign shl     = {acc_hi, acc_lo[DATA_W-1]};
  assign ge      = (shl >= {1'b0, opnd});
  // When ge holds the difference is below the divisor, so 32 bits suffice.
  assign diff    = shl[DATA_W-1:0] - opnd;
  assign iter_hi = is_div ? (ge ? diff : shl[DATA_W-1:0]) : add_sum[DATA_W:1];
  assign iter_lo = is_div ? {acc_lo[DATA_W-2:0], ge} : {add_sum[0], acc_lo[DATA_W-1:1]};

`ifdef MDU_SIGNED_EN
  logic sgn_op;
  logic neg_lo_r;  // product sign (multiply) or quotient sign (divide)
  logic neg_hi_r;  // remainder sign: follows the dividend
  logic [2*DATA_W-1:0] prod_fix;

  assign sgn_op = op[0];

  function automatic logic [DATA_W-1:0] mag32(input logic signed [DATA_W-1:0] x,
                                              input logic en);
    return (en && (x < 0)) ? -x : x;
  endfunction

  function automatic logic [DATA_W-1:0] neg32(input logic [DATA_W-1:0] x, input logic en);
    return en ? -x : x;
  endfunction

  function automatic logic [2*DATA_W-1:0] neg64(input logic [2*DATA_W-1:0] x, input logic en);
    return en ? -x : x;
  endfunction

  assign a_mag    = mag32(A, sgn_op);
  assign b_mag    = mag32(B, sgn_op);
  assign prod_fix = neg64({acc_hi, acc_lo}, neg_lo_r);
  assign fix_hi   = is_div ? neg32(acc_hi, neg_hi_r) : prod_fix[2*DATA_W-1:DATA_W];
  assign fix_lo   = is_div ? neg32(acc_lo, neg_lo_r) : prod_fix[DATA_W-1:0];

  // Sign flags captured at accept; a divide by zero bypasses correction
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      neg_lo_r <= 1'b0;
      neg_hi_r <= 1'b0;
    end else if (accept) begin
      neg_lo_r <= !dbz_req && sgn_op && (A[DATA_W-1] ^ B[DATA_W-1]);
      neg_hi_r <= !dbz_req && sgn_op && op[1] && A[DATA_W-1];
    end
  end
`else
  logic unused_op0;
  assign unused_op0 = op[0];
  assign a_mag      = A;
  assign b_mag      = B;
  assign fix_hi     = acc_hi;
  assign fix_lo     = acc_lo;
`endif

  // State register; reset aborts any operation in flight
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state and accept decode; a divide by zero skips RUN entirely
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    dbz_req   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept = 1'b1;
          if (op[1] && (B == '0)) begin
            dbz_req   = 1'b1;
            state_nxt = FIX;
          end else begin
            state_nxt = RUN;
          end
        end
      end
      RUN:     if (cnt == 5'd31) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Control flags: busy, done pulse, sticky divide-by-zero and iteration count
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      cnt         <= '0;
    end else begin
      done <= (state == FIX);
      if (accept) begin
        busy        <= 1'b1;
        cnt         <= '0;
        div_by_zero <= dbz_req;
      end else if (state == RUN) begin
        cnt <= cnt + 5'd1;
      end else if (state == FIX) begin
        busy <= 1'b0;
      end
    end
  end

  // Working accumulator: loaded on accept, stepped once per RUN cycle
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      is_div <= 1'b0;
      acc_hi <= '0;
      acc_lo <= '0;
      opnd   <= '0;
    end else if (accept) begin
      is_div <= op[1];
      if (dbz_req) begin
        acc_hi <= A;
        acc_lo <= {DATA_W{1'b1}};
        opnd   <= '0;
      end else begin
        acc_hi <= '0;
        acc_lo <= op[1] ? a_mag : b_mag;
        opnd   <= op[1] ? b_mag : a_mag;
      end
    end else if (state == RUN) begin
      acc_hi <= iter_hi;
      acc_lo <= iter_lo;
    end
  end

  // Architectural HI/LO change only at FIX; result re-selects every edge
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      HI     <= '0;
      LO     <= '0;
      result <= '0;
    end else begin
      if (state == FIX) begin
        HI <= fix_hi;
        LO <= fix_lo;
      end
      result <= sel_hi ? HI : LO;
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: randomized scoreboard bench for mult_div_unit.
module tb_mult_div_unit;

  logic        CLK = 1'b0;
  logic        Reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] A, B;
  logic        sel_hi;
  logic        busy, done, div_by_zero;
  logic [31:0] HI, LO, result;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
    int          due;
  } exp_t;

  exp_t exp_q[$];

  mult_div_unit dut (
    .CLK(CLK), .Reset(Reset), .start(start), .op(op), .A(A), .B(B),
    .sel_hi(sel_hi), .busy(busy), .done(done), .div_by_zero(div_by_zero),
    .HI(HI), .LO(LO), .result(result)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running, required finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Reference model: plain arithmetic on the architectural rules
  function automatic exp_t model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    bit sgn;
    logic signed [63:0] sa, sb, sp, q, r;
    logic [63:0] up;
`ifdef MDU_SIGNED_EN
    sgn = o[0];
`else
    sgn = 1'b0;
`endif
    e.dbz = 1'b0;
    e.due = 0;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    if (!o[1]) begin
      if (sgn) begin
        sp   = sa * sb;
        e.hi = sp[63:32];
        e.lo = sp[31:0];
      end else begin
        up   = {32'd0, a} * {32'd0, b};
        e.hi = up[63:32];
        e.lo = up[31:0];
      end
    end else if (b == 32'd0) begin
      e.hi  = a;
      e.lo  = 32'hFFFF_FFFF;
      e.dbz = 1'b1;
    end else if (sgn) begin
      q    = sa / sb;
      r    = sa % sb;
      e.lo = q[31:0];
      e.hi = r[31:0];
    end else begin
      e.lo = a / b;
      e.hi = a % b;
    end
    return e;
  endfunction

  // Monitor: pops an expectation on every done pulse; checks HI/LO hold otherwise
  logic [31:0] prev_hi = '0, prev_lo = '0, res_exp = '0;
  bit          res_pend = 1'b0;
  always @(negedge CLK) begin
    exp_t e;
    if (Reset) begin
      prev_hi  = '0;
      prev_lo  = '0;
      res_pend = 1'b0;
    end else begin
      if (res_pend) begin
        chk("result_select", result, res_exp);
        res_pend = 1'b0;
      end
      if (done) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL done_unexpected: done=1 with no operation pending, required done=0");
        end else begin
          e = exp_q.pop_front();
          chk("hi", HI, e.hi);
          chk("lo", LO, e.lo);
          chk("div_by_zero", 32'(div_by_zero), 32'(e.dbz));
          chk("latency_cycle", 32'(cyc), 32'(e.due));
          chk("busy_at_done", 32'(busy), 32'd0);
          res_exp  = sel_hi ? e.hi : e.lo;
          res_pend = 1'b1;
        end
      end else begin
        chk("hi_hold", HI, prev_hi);
        chk("lo_hold", LO, prev_lo);
      end
      prev_hi = HI;
      prev_lo = LO;
    end
  end

  // Drive one start pulse; acc reports whether the DUT was free to take it
  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic s, output bit acc);
    exp_t e;
    op = o; A = a; B = b; sel_hi = s; start = 1'b1;
    acc = !busy;
    e = model(o, a, b);
    @(posedge CLK);
    #1;
    if (acc) begin
      e.due = cyc + ((o[1] && (b == 32'd0)) ? 1 : 33);
      exp_q.push_back(e);
    end
    #1 start = 1'b0;
  endtask

  // Wait for busy to drop; returns 2 time units after an edge
  task automatic wait_idle();
    int k = 0;
    while (busy && k < 100) begin
      @(posedge CLK);
      #2;
      k++;
    end
    if (busy) begin
      n_checks++;
      n_fail++;
      $display("FAIL busy_timeout: busy=1 after 100 cycles, required busy=0");
    end
  endtask

  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic s);
    bit acc;
    issue(o, a, b, s, acc);
    chk("accepted", 32'(acc), 32'd1);
    wait_idle();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_dbz"}, 32'(div_by_zero), 32'd0);
    chk({tag, "_hi"}, HI, 32'd0);
    chk({tag, "_lo"}, LO, 32'd0);
    chk({tag, "_result"}, result, 32'd0);
  endtask

  initial begin
    bit          acc;
    logic [1:0]  o;
    logic [31:0] a, b;

    Reset = 1'b1; start = 1'b0; op = '0; A = '0; B = '0; sel_hi = 1'b0;
    repeat (3) @(posedge CLK);
    #2;
    chk_all_zero("reset");
    Reset = 1'b0;
    @(posedge CLK);
    #2;

    // Directed cases from the operating rules
    run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    run_op(2'b01, 32'hFFFF_FFFD, 32'd5, 1'b0);
    run_op(2'b11, 32'hFFFF_FFF9, 32'd2, 1'b1);
    run_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_op(2'b10, 32'd100, 32'd0, 1'b1);
    chk("dbz_sticky_idle", 32'(div_by_zero), 32'd1);
    run_op(2'b11, 32'd0, 32'd0, 1'b0);
    run_op(2'b10, 32'd7, 32'd3, 1'b1);

    // Start during RUN is ignored, single completion with original operands
    issue(2'b00, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1, acc);
    chk("accepted", 32'(acc), 32'd1);
    repeat (8) @(posedge CLK);
    #2;
    issue(2'b01, 32'd1, 32'd1, 1'b0, acc);
    chk("start_ignored_when_busy", 32'(acc), 32'd0);
    wait_idle();

    // Reset mid-RUN clears everything immediately
    issue(2'b00, 32'hDEAD_BEEF, 32'h0000_0F0F, 1'b1, acc);
    repeat (14) @(posedge CLK);
    #1 Reset = 1'b1;
    #1;
    chk_all_zero("async_reset");
    exp_q.delete();
    repeat (2) @(posedge CLK);
    #2 Reset = 1'b0;
    @(posedge CLK);
    #2;
    run_op(2'b01, 32'h7FFF_FFFF, 32'h8000_0000, 1'b0);

    // Randomized operations, each started in the done cycle of the previous one
    for (int i = 0; i < 40; i++) begin
      o = 2'($urandom_range(0, 3));
      a = $urandom;
      case ($urandom_range(0, 5))
        0:       b = 32'd0;
        1:       b = 32'($urandom_range(1, 15));
        2:       b = -32'($urandom_range(1, 15));
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
      run_op(o, a, b, 1'($urandom_range(0, 1)));
    end

    repeat (3) @(posedge CLK);
    #2;
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
